// File: rtl/attn_job_scheduler_pkg.sv
// Shared constants and FSM encoding for the attention PE job scheduler.
package attn_job_scheduler_pkg;
  localparam int DATA_W = 16;
  localparam int ELEMS  = 32;
  localparam int VEC_W  = DATA_W * ELEMS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/attn_job_scheduler_arb.sv
// Round-robin arbiter: search starts at rr_ptr, pointer moves past the winner on accept.
module attn_rr_arbiter
  import attn_job_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);
  logic [ID_W-1:0] rr_ptr;

  always_comb begin
    int j;
    j       = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  assign gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else if (accept) rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/attn_job_scheduler.sv
// Shares one 8x8 attention PE among NUM_REQ requesters: grant, clear, run, return result.
// Define ATTN_SCHED_TIMEOUT_EN to abort a RUN that sees no all_done within TIMEOUT cycles.
module attn_job_scheduler
  import attn_job_scheduler_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int CLR_CYCLES = 2,
  parameter  int TIMEOUT    = 4096,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_key,
  input  logic [NUM_REQ*VEC_W-1:0] req_query,
  input  logic [NUM_REQ*VEC_W-1:0] req_value,
  output logic                     pe_rst_n,
  output logic                     pe_en,
  output logic [VEC_W-1:0]         pe_key,
  output logic [VEC_W-1:0]         pe_query,
  output logic [VEC_W-1:0]         pe_value,
  input  logic [VEC_W-1:0]         pe_final_res,
  input  logic                     pe_all_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VEC_W-1:0]         out_res,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_err,
  output logic                     busy,
  output logic [15:0]              job_cnt
);
`ifdef ATTN_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               accept;
  logic [CLR_W-1:0]   clr_cnt;
  logic [TO_W-1:0]    run_cnt;
  logic               run_seen;
  logic               timed_out;

  assign accept    = (state == ST_IDLE) && gnt_any;
  assign busy      = (state != ST_IDLE);
  assign timed_out = TO_EN && (run_cnt == TO_W'(TIMEOUT - 1));

  attn_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= '0;
      pe_rst_n  <= 1'b0;
      pe_en     <= 1'b0;
      pe_key    <= '0;
      pe_query  <= '0;
      pe_value  <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
      job_cnt   <= '0;
      clr_cnt   <= '0;
      run_cnt   <= '0;
      run_seen  <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        ST_IDLE: begin
          pe_rst_n <= 1'b1;
          pe_en    <= 1'b0;
          if (gnt_any) begin
            req_ready <= gnt;
            pe_key    <= req_key[gnt_idx*VEC_W +: VEC_W];
            pe_query  <= req_query[gnt_idx*VEC_W +: VEC_W];
            pe_value  <= req_value[gnt_idx*VEC_W +: VEC_W];
            out_id    <= gnt_idx;
            pe_rst_n  <= 1'b0;
            clr_cnt   <= '0;
            state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
            pe_rst_n <= 1'b1;
            pe_en    <= 1'b1;
            run_seen <= 1'b0;
            run_cnt  <= '0;
            state    <= ST_RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // all_done on the first RUN cycle may be stale from before the PE reset
          run_seen <= 1'b1;
          run_cnt  <= run_cnt + 1'b1;
          if (run_seen && pe_all_done) begin
            out_res   <= pe_final_res;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            pe_en     <= 1'b0;
            state     <= ST_DONE;
          end else if (timed_out) begin
            out_res   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            pe_en     <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            job_cnt   <= job_cnt + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_attn_job_scheduler.sv
// Scoreboard bench for attn_job_scheduler with a behavioural PE model.
module tb_attn_job_scheduler;
  localparam int NR = 2;
  localparam int VW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*VW-1:0] req_key = '0, req_query = '0, req_value = '0;
  logic             pe_rst_n, pe_en;
  logic [VW-1:0]    pe_key, pe_query, pe_value;
  logic [VW-1:0]    pe_final_res = '0;
  logic             pe_all_done = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [VW-1:0]    out_res;
  logic [0:0]       out_id;
  logic             out_err;
  logic             busy;
  logic [15:0]      job_cnt;

  attn_job_scheduler #(.NUM_REQ(NR), .CLR_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_query(req_query), .req_value(req_value),
    .pe_rst_n(pe_rst_n), .pe_en(pe_en), .pe_key(pe_key), .pe_query(pe_query),
    .pe_value(pe_value), .pe_final_res(pe_final_res), .pe_all_done(pe_all_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_id(out_id),
    .out_err(out_err), .busy(busy), .job_cnt(job_cnt)
  );

  // Directed vectors; expected result = key ^ query ^ value, worked by hand per 16-bit lane
  logic [VW-1:0] K0 = {32{16'h0101}}, Q0 = {32{16'h00F0}}, V0 = {32{16'h1234}};
  logic [VW-1:0] K1 = {32{16'hA5A5}}, Q1 = {32{16'h0F0F}}, V1 = {32{16'h8001}};
  logic [VW-1:0] EXP0 = {32{16'h13C5}}, EXP1 = {32{16'h2AAB}};
  logic [VW-1:0] JUNK = {32{16'hDEAD}};
  logic [VW-1:0] ZERO = '0;

  typedef struct {
    int            id;
    logic [VW-1:0] res;
    int            err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, passed = 0;
  int gcnt = 0;
  int pe_mode = 0;  // 0 normal, 1 never done, 2 early/spurious done
  int run_ctr = 0;
  int jexp = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // PE model: result is the xor of whatever the scheduler latched onto pe_*
  initial forever begin
    @(posedge clk); #1;
    if (!pe_rst_n) run_ctr = 0;
    else if (pe_en) run_ctr++;
    case (pe_mode)
      0: begin
        pe_all_done  = pe_rst_n && pe_en && (run_ctr >= 3);
        pe_final_res = pe_key ^ pe_query ^ pe_value;
      end
      1: begin
        pe_all_done  = 1'b0;
        pe_final_res = JUNK;
      end
      default: begin
        pe_all_done  = !pe_rst_n || (pe_en && (run_ctr == 1 || run_ctr >= 5));
        pe_final_res = (run_ctr >= 5) ? (pe_key ^ pe_query ^ pe_value) : JUNK;
      end
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && req_ready != '0) gcnt++;
  end

  // Scoreboard monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got id %0d with no expected entry", out_id);
      end else begin
        e = exp_q.pop_front();
        chk_i("out_id", int'(out_id), e.id);
        chk("out_res", out_res, e.res);
        chk_i("out_err", int'(out_err), e.err);
      end
    end
  end

  task automatic wait_ready(input int i);
    bit ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
    chk_i($sformatf("grant_req%0d", i), int'(ok), 1);
  endtask

  task automatic issue(input int i);
    req_valid[i] = 1'b1;
    wait_ready(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_jobs(input int n);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (int'(job_cnt) == n) break;
    end
    chk_i("job_cnt", int'(job_cnt), n);
  endtask

  task automatic wait_any_grant(output logic [NR-1:0] g);
    g = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin g = req_ready; break; end
    end
  endtask

  initial begin
    logic [NR-1:0] g;
    logic [VW-1:0] held;
    int lows, bad, g0, cnt;
    req_key   = {K1, K0};
    req_query = {Q1, Q0};
    req_value = {V1, V0};

    // Reset state, with requests pending that must not be granted
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", VW'(req_ready), ZERO);
    chk_i("rst_pe_rst_n", int'(pe_rst_n), 0);
    chk_i("rst_pe_en", int'(pe_en), 0);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_job_cnt", int'(job_cnt), 0);
    chk("rst_out_res", out_res, ZERO);
    chk("rst_pe_key", pe_key, ZERO);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_i("idle_pe_rst_n", int'(pe_rst_n), 1);

    // Single job
    exp_q.push_back('{0, EXP0, 0});
    issue(0);
    lows = 0;
    while (!pe_rst_n && lows < 20) begin lows++; @(negedge clk); end
    chk_i("clear_cycles", lows, 2);
    jexp = 1;
    wait_jobs(jexp);
    chk_i("single_grant_pulses", gcnt, 1);

    // Contention from a fresh pointer
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk_i("reset_job_cnt", int'(job_cnt), 0);
    gcnt = 0;
    exp_q.push_back('{0, EXP0, 0});
    exp_q.push_back('{1, EXP1, 0});
    exp_q.push_back('{0, EXP0, 0});
    exp_q.push_back('{1, EXP1, 0});
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_any_grant(g);
      if (k == 3) req_valid = '0;
      chk($sformatf("contention_grant%0d", k), VW'(g), VW'((k % 2 == 0) ? 2'b01 : 2'b10));
    end
    jexp = 4;
    wait_jobs(jexp);
    chk_i("contention_grant_total", gcnt, 4);

    // Backpressure
    out_ready = 1'b0;
    exp_q.push_back('{0, EXP0, 0});
    exp_q.push_back('{1, EXP1, 0});
    issue(0);
    req_valid[1] = 1'b1;
    for (int c = 0; c < 60 && !out_valid; c++) @(negedge clk);
    chk_i("bp_out_valid", int'(out_valid), 1);
    g0 = gcnt;
    held = out_res;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_res !== held || req_ready != '0) bad++;
    end
    chk_i("bp_hold_violations", bad, 0);
    chk_i("bp_no_grants", gcnt - g0, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_i("bp_release_idle", int'(busy), 0);
    wait_ready(1);
    req_valid[1] = 1'b0;
    jexp = 6;
    wait_jobs(jexp);

    // Spurious all_done during CLEAR and first RUN cycle
    pe_mode = 2;
    exp_q.push_back('{0, EXP0, 0});
    issue(0);
    jexp = 7;
    wait_jobs(jexp);
    pe_mode = 0;

    // PE that never finishes
    pe_mode = 1;
`ifdef ATTN_SCHED_TIMEOUT_EN
    exp_q.push_back('{0, ZERO, 1});
    issue(1);
    cnt = 0;
    for (int c = 0; c < 100 && !out_valid; c++) begin
      if (pe_en) cnt++;
      @(negedge clk);
    end
    chk_i("timeout_run_cycles", cnt, 16);
    jexp = 8;
    wait_jobs(jexp);
    issue(0);
    repeat (5) @(negedge clk);
`else
    issue(0);
    repeat (40) @(negedge clk);
    chk_i("stuck_busy", int'(busy), 1);
    chk_i("stuck_pe_en", int'(pe_en), 1);
    chk_i("stuck_no_valid", int'(out_valid), 0);
`endif

    // Reset mid-RUN: pointer was left at 1, reset must return it to 0
    chk_i("queue_drained_pre_reset", exp_q.size(), 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk_i("midrun_pe_rst_n", int'(pe_rst_n), 0);
    chk_i("midrun_pe_en", int'(pe_en), 0);
    chk_i("midrun_busy", int'(busy), 0);
    chk_i("midrun_out_valid", int'(out_valid), 0);
    chk_i("midrun_job_cnt", int'(job_cnt), 0);
    chk("midrun_pe_key", pe_key, ZERO);
    @(posedge clk); #2 rst_n = 1'b1;
    pe_mode = 0;
    exp_q.push_back('{0, EXP0, 0});
    req_valid = 2'b11;
    wait_any_grant(g);
    req_valid = '0;
    chk("post_reset_grant", VW'(g), VW'(2'b01));
    jexp = 1;
    wait_jobs(jexp);

    repeat (3) @(negedge clk);
    chk_i("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
